// File: rtl/mlp_pkg.sv
// mlp_pkg: shared MLP feature-vector defaults and loader assembly states,
// also used by the classifier wrapper.
package mlp_pkg;
   localparam int N_FEAT_DEF = 21;
   localparam int FEAT_W_DEF = 4;
   typedef enum logic {FILL, STALL} fill_state_e;
endpackage

// File: rtl/mlp_vec_reg.sv
// mlp_vec_reg: skid-free holding register for a completed feature vector.
// o_valid stays up through a consume cycle when a new vector loads in the same cycle.
module mlp_vec_reg
   import mlp_pkg::*;
#(
   parameter int W = N_FEAT_DEF * FEAT_W_DEF
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data
);
   logic         r_valid;
   logic [W-1:0] r_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else begin
         r_valid <= i_load | (r_valid & ~i_ready);
         if (i_load) r_data <= i_data;
      end
   assign o_valid = r_valid;
   assign o_data  = r_data;
endmodule

// File: rtl/mlp_feature_loader.sv
// mlp_feature_loader: assembles a serial feature stream into one parallel
// vector per frame for the classifier, with sof-based resynchronisation.
module mlp_feature_loader
   import mlp_pkg::*;
#(
   parameter int N_FEAT = N_FEAT_DEF,
   parameter int FEAT_W = FEAT_W_DEF
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [FEAT_W-1:0]        in_feat,
   input  logic                     in_sof,
   output logic                     vec_valid,
   input  logic                     vec_ready,
   output logic [N_FEAT*FEAT_W-1:0] vec,
   output logic                     err_sync,
   output logic [15:0]              frame_cnt
);
   localparam int IW = N_FEAT > 1 ? $clog2(N_FEAT) : 1;
   localparam int VW = N_FEAT * FEAT_W;
   fill_state_e   r_state;
   logic [IW-1:0] r_idx;
   logic [VW-1:0] r_asm;
   logic          r_err;
   logic [15:0]   r_cnt;
   logic          w_acc, w_free, w_last, w_xfer;
   logic [IW-1:0] w_slot;
   logic [VW-1:0] w_asm;
   assign in_ready = r_state == FILL;
   assign w_acc    = in_valid & in_ready;
   assign w_free   = ~vec_valid | vec_ready;
   assign w_slot   = in_sof ? '0 : r_idx;
   assign w_last   = w_acc & (w_slot == IW'(N_FEAT - 1));
   // a stalled assembly and a just-completed one both leave through the same path
   assign w_xfer   = w_free & (w_last | (r_state == STALL));
   always_comb begin
      w_asm = r_asm;
      if (w_acc) w_asm[w_slot*FEAT_W +: FEAT_W] = in_feat;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_state <= FILL;
         r_idx   <= '0;
         r_asm   <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_asm   <= w_asm;
         r_err   <= w_acc & in_sof & (r_idx != '0);
         r_cnt   <= r_cnt + {15'd0, w_xfer};
         if (w_acc) r_idx <= w_last ? '0 : w_slot + 1'b1;
         r_state <= ((w_last | (r_state == STALL)) & ~w_free) ? STALL : FILL;
      end
   mlp_vec_reg #(.W(VW)) u_vec_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_xfer),
      .i_data  (w_asm),
      .i_ready (vec_ready),
      .o_valid (vec_valid),
      .o_data  (vec)
   );
   assign err_sync  = r_err;
   assign frame_cnt = r_cnt;
endmodule

// File: doc/mlp_feature_loader.md
MLP_FEATURE_LOADER -- requirements
Module: mlp_feature_loader

Interface
REQ-001 SHALL have parameter N_FEAT, default 21: number of features per frame.
REQ-002 SHALL have parameter FEAT_W, default 4: unsigned bits per feature.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: in_feat/in_sof are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1: loader accepts a feature this cycle.
REQ-007 SHALL have port in_feat, input, FEAT_W: one feature value, unsigned.
REQ-008 SHALL have port in_sof, input, 1: this feature is feature 0 of a frame.
REQ-009 SHALL have port vec_valid, output, 1: vec holds a complete frame.
REQ-010 SHALL have port vec_ready, input, 1: downstream classifier consumes vec.
REQ-011 SHALL have port vec, output, N_FEAT*FEAT_W: feature i at bits [FEAT_W*i+FEAT_W-1 : FEAT_W*i], directly feeding the classifier inp bus.
REQ-012 SHALL have port err_sync, output, 1: one-cycle pulse on frame resynchronisation.
REQ-013 SHALL have port frame_cnt, output, 16: completed frames delivered, wraps 0xFFFF->0.

Function
REQ-014 A feature SHALL be accepted only when in_valid and in_ready are both 1 on a clock edge.
REQ-015 An accepted feature SHALL be written to assembly slot idx, then idx SHALL increment; idx range 0..N_FEAT-1.
REQ-016 An accepted feature with in_sof=1 SHALL be written to slot 0 and set idx=1; if idx was nonzero, err_sync SHALL pulse high the next cycle and the partial frame SHALL be discarded.
REQ-017 in_sof=0 with idx=0 SHALL be accepted as feature 0 without error.
REQ-018 Assembly FSM states SHALL be FILL and STALL; in_ready SHALL be 1 in FILL and 0 in STALL.
REQ-019 On acceptance into slot N_FEAT-1: if output register free (vec_valid=0 or vec_ready=1) the complete vector SHALL move to vec and vec_valid SHALL be 1 the next cycle (latency 1 cycle from last feature); otherwise FSM SHALL enter STALL holding the assembly.
REQ-020 In STALL, the first cycle the output register is free the assembly SHALL transfer to vec, idx SHALL clear to 0 and FSM SHALL return to FILL.
REQ-021 vec_valid SHALL clear after a vec_ready=1 cycle unless a new vector transfers in that same cycle, in which case vec_valid stays 1 (back-to-back, no bubble).
REQ-022 vec SHALL remain stable while vec_valid=1 and vec_ready=0.
REQ-023 frame_cnt SHALL increment by 1 on each transfer into vec, modulo 2^16.
REQ-024 Sustained throughput SHALL be N_FEAT cycles per frame with vec_ready held 1.
REQ-025 Slots not rewritten SHALL hold prior values; no zeroing between frames.

Reset
REQ-026 rst_n=0 SHALL immediately force: FSM FILL, idx 0, vec_valid 0, vec all zeros, err_sync 0, frame_cnt 0, assembly all zeros.
REQ-027 Reset mid-frame or with vec_valid=1 SHALL discard all data; first accepted feature after release is feature 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-029 N_FEAT, FEAT_W defaults and the FSM state enum SHALL live in a shared package mlp_pkg, reused by the classifier wrapper.
REQ-030 Output register plus vec_valid/vec_ready logic SHALL be a sub-module mlp_vec_reg (skid-free holding register); the rest stays flat.

Verification
REQ-031 Reset, stream 21 features i=0..20 with in_feat=i mod 16, vec_ready=1 -> vec_valid=1 one cycle after feature 20; vec[3:0]=0, vec[83:80]=4; frame_cnt=1.
REQ-032 Two frames back-to-back, vec_ready=0 until cycle 50 -> FSM stalls after frame 2's last feature, in_ready=0; vec holds frame 1; frame 2 appears the cycle after vec_ready=1; no data loss.
REQ-033 Send 7 features, then feature with in_sof=1 value 0xA -> err_sync pulses once; after 20 more features vec[3:0]=0xA and frame completes with 21 total accepted since sof.
REQ-034 Assert rst_n=0 after 10 features of a frame -> all outputs at reset values immediately; new 21-feature frame completes correctly.
REQ-035 Random in_valid/vec_ready toggling, 1000 frames -> every vec matches reference frame order; frame_cnt=1000 mod 65536.
REQ-036 Preload frame_cnt to 0xFFFF via 65535 frames (or force) -> next frame delivers, frame_cnt=0x0000.
